// File: rtl/apb_req_arbiter.sv
// Two-port round-robin APB3 master: arbitrates between two command ports, runs SETUP/ACCESS,
// decodes 16 PSEL slots from PADDR[27:24] and aborts transfers to slaves that stall too long.
module apb_req_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        REQ0,
  input  logic        WRITE0,
  input  logic [31:0] ADDR0,
  input  logic [31:0] WDATA0,
  output logic        ACK0,
  input  logic        REQ1,
  input  logic        WRITE1,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA1,
  output logic        ACK1,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic        GNT_ID,
  output logic        BUSY,
  output logic [15:0] PSEL,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  // Counter value seen on the wait cycle that must abort; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] TimeoutLast = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        ack0_d, ack1_d, err_d, gnt_d, busy_d, pwrite_d, penable_d;
  logic [31:0] rdata_d, paddr_d, pwdata_d;
  logic [15:0] psel_d;

  logic        pick;
  logic [31:0] sel_addr;

  always_comb begin
    // Both requesting: the one not granted last time wins.
    pick     = (REQ0 && REQ1) ? ~GNT_ID : REQ1;
    sel_addr = pick ? ADDR1 : ADDR0;

    state_d   = state_q;
    cnt_d     = cnt_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata_d   = RDATA;
    err_d     = ERR;
    gnt_d     = GNT_ID;
    psel_d    = PSEL;
    paddr_d   = PADDR;
    pwrite_d  = PWRITE;
    penable_d = PENABLE;
    pwdata_d  = PWDATA;

    case (state_q)
      StIdle: begin
        if (REQ0 || REQ1) begin
          gnt_d    = pick;
          paddr_d  = sel_addr;
          pwrite_d = pick ? WRITE1 : WRITE0;
          pwdata_d = pick ? WDATA1 : WDATA0;
          psel_d   = 16'h0001 << sel_addr[27:24];
          state_d  = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          rdata_d   = PRDATA;
          err_d     = PSLVERR;
          psel_d    = '0;
          penable_d = 1'b0;
          ack0_d    = ~GNT_ID;
          ack1_d    = GNT_ID;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            psel_d    = '0;
            penable_d = 1'b0;
            ack0_d    = ~GNT_ID;
            ack1_d    = GNT_ID;
            state_d   = StDone;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ACK0    <= 1'b0;
      ACK1    <= 1'b0;
      RDATA   <= '0;
      ERR     <= 1'b0;
      GNT_ID  <= 1'b1;
      BUSY    <= 1'b0;
      PSEL    <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PENABLE <= 1'b0;
      PWDATA  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ACK0    <= ack0_d;
      ACK1    <= ack1_d;
      RDATA   <= rdata_d;
      ERR     <= err_d;
      GNT_ID  <= gnt_d;
      BUSY    <= busy_d;
      PSEL    <= psel_d;
      PADDR   <= paddr_d;
      PWRITE  <= pwrite_d;
      PENABLE <= penable_d;
      PWDATA  <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed transfers, scoreboard of expected completions popped on ACK.
module tb_apb_req_arbiter;

  logic        HCLK, HRESETN;
  logic        REQ0, WRITE0, REQ1, WRITE1;
  logic [31:0] ADDR0, WDATA0, ADDR1, WDATA1;
  logic        ACK0, ACK1, ERR, GNT_ID, BUSY, PWRITE, PENABLE, PREADY, PSLVERR;
  logic [31:0] RDATA, PADDR, PWDATA, PRDATA;
  logic [15:0] PSEL;

  // Second instance with the timeout disabled, driven directly.
  logic        z_REQ0, z_WRITE0, z_REQ1, z_WRITE1;
  logic [31:0] z_ADDR0, z_WDATA0, z_ADDR1, z_WDATA1;
  logic        z_ACK0, z_ACK1, z_ERR, z_GNT_ID, z_BUSY, z_PWRITE, z_PENABLE, z_PREADY, z_PSLVERR;
  logic [31:0] z_RDATA, z_PADDR, z_PWDATA, z_PRDATA;
  logic [15:0] z_PSEL;

  apb_req_arbiter #(.TIMEOUT(4), .CNT_W(8)) u_dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .REQ0(REQ0), .WRITE0(WRITE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(ACK0),
    .REQ1(REQ1), .WRITE1(WRITE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(ACK1),
    .RDATA(RDATA), .ERR(ERR), .GNT_ID(GNT_ID), .BUSY(BUSY),
    .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_req_arbiter #(.TIMEOUT(0), .CNT_W(8)) u_dut_nto (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .REQ0(z_REQ0), .WRITE0(z_WRITE0), .ADDR0(z_ADDR0), .WDATA0(z_WDATA0), .ACK0(z_ACK0),
    .REQ1(z_REQ1), .WRITE1(z_WRITE1), .ADDR1(z_ADDR1), .WDATA1(z_WDATA1), .ACK1(z_ACK1),
    .RDATA(z_RDATA), .ERR(z_ERR), .GNT_ID(z_GNT_ID), .BUSY(z_BUSY),
    .PSEL(z_PSEL), .PADDR(z_PADDR), .PWRITE(z_PWRITE), .PENABLE(z_PENABLE), .PWDATA(z_PWDATA),
    .PRDATA(z_PRDATA), .PREADY(z_PREADY), .PSLVERR(z_PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          id;
    bit          err;
    bit          chk_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat0, lat1, lat_m;

  // Slave model configuration
  int          cfg_wait = 0;
  bit          cfg_err = 0;
  bit          cfg_err_wait = 0;
  logic [31:0] cfg_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit id, input bit err, input bit chk_data, input logic [31:0] rd);
    exp_t e;
    e.id = id; e.err = err; e.chk_data = chk_data; e.rdata = rd;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; holds the command until ACK is sampled, then drops REQ.
  task automatic do_req(input bit id, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    if (id) begin REQ1 = 1'b1; WRITE1 = wr; ADDR1 = addr; WDATA1 = wdata; end
    else    begin REQ0 = 1'b1; WRITE0 = wr; ADDR0 = addr; WDATA0 = wdata; end
    while (!seen && lat < 60) begin
      @(negedge HCLK);
      lat++;
      seen = id ? ACK1 : ACK0;
    end
    chk("ack_wait", 32'(seen), 32'd1);
    if (id) REQ1 = 1'b0;
    else    REQ0 = 1'b0;
  endtask

  // APB slave: PREADY rises after cfg_wait ACCESS cycles.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge HCLK);
      if (PSEL != 16'h0 && PENABLE) begin
        PREADY = (acc_cnt >= cfg_wait);
        acc_cnt++;
      end else begin
        PREADY  = 1'b0;
        acc_cnt = 0;
      end
      PSLVERR = PREADY ? cfg_err : cfg_err_wait;
      PRDATA  = cfg_rdata;
    end
  end

  // Monitor: pops the scoreboard on each completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESETN) begin
        if (!$onehot0(PSEL)) chk("psel_onehot", 32'(PSEL), 32'h0);
        if (ACK0 || ACK1) begin
          chk("ack_exclusive", 32'(ACK0 & ACK1), 32'd0);
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_ack", 32'(ACK1), 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            chk("ack_id", 32'(ACK1), 32'(e.id));
            chk("gnt_id", 32'(GNT_ID), 32'(e.id));
            chk("err", 32'(ERR), 32'(e.err));
            if (e.chk_data) chk("rdata", RDATA, e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  z_bad;
    HRESETN = 1'b0;
    REQ0 = 0; WRITE0 = 0; ADDR0 = '0; WDATA0 = '0;
    REQ1 = 0; WRITE1 = 0; ADDR1 = '0; WDATA1 = '0;
    z_REQ0 = 0; z_WRITE0 = 0; z_ADDR0 = '0; z_WDATA0 = '0;
    z_REQ1 = 0; z_WRITE1 = 0; z_ADDR1 = '0; z_WDATA1 = '0;
    z_PRDATA = '0; z_PREADY = 0; z_PSLVERR = 0;

    @(negedge HCLK);
    chk("rst_psel", 32'(PSEL), 32'h0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_ack", 32'({ACK1, ACK0}), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_gnt", 32'(GNT_ID), 32'd1);
    @(negedge HCLK);
    HRESETN = 1'b1;
    repeat (2) @(negedge HCLK);

    // Single zero-wait write
    push(0, 0, 0, 32'h0);
    fork
      do_req(0, 1, 32'h0300_0010, 32'hA5A5_1234, lat_m);
      begin
        @(negedge HCLK);
        chk("wr_setup_psel", 32'(PSEL), 32'h0008);
        chk("wr_setup_penable", 32'(PENABLE), 32'd0);
        chk("wr_pwrite", 32'(PWRITE), 32'd1);
        chk("wr_pwdata", PWDATA, 32'hA5A5_1234);
        chk("wr_paddr", PADDR, 32'h0300_0010);
        chk("wr_busy", 32'(BUSY), 32'd1);
        @(negedge HCLK);
        chk("wr_access_psel", 32'(PSEL), 32'h0008);
        chk("wr_access_penable", 32'(PENABLE), 32'd1);
      end
    join
    chk("wr_latency", 32'(lat_m), 32'd3);
    repeat (2) @(negedge HCLK);

    // Read with two wait states
    cfg_wait = 2; cfg_rdata = 32'hDEAD_BEEF;
    push(1, 0, 1, 32'hDEAD_BEEF);
    fork
      do_req(1, 0, 32'h0F00_0004, 32'h0, lat_m);
      begin
        @(negedge HCLK);
        chk("rd_psel", 32'(PSEL), 32'h8000);
        chk("rd_pwrite", 32'(PWRITE), 32'd0);
      end
    join
    chk("rd_latency", 32'(lat_m), 32'd5);
    repeat (2) @(negedge HCLK);

    // Slave error, then a clean transfer
    cfg_wait = 0; cfg_err = 1;
    push(0, 1, 0, 32'h0);
    do_req(0, 1, 32'h0100_0000, 32'h0000_0011, lat_m);
    repeat (2) @(negedge HCLK);
    cfg_err = 0; cfg_rdata = 32'h0BAD_F00D;
    push(1, 0, 1, 32'h0BAD_F00D);
    do_req(1, 0, 32'h0200_0008, 32'h0, lat_m);
    repeat (2) @(negedge HCLK);

    // PSLVERR high only while PREADY is low must be ignored
    cfg_wait = 2; cfg_err_wait = 1; cfg_rdata = 32'h1357_9BDF;
    push(0, 0, 1, 32'h1357_9BDF);
    do_req(0, 0, 32'h0400_0000, 32'h0, lat_m);
    cfg_err_wait = 0;
    repeat (2) @(negedge HCLK);

    // Timeout abort after 4 wait cycles
    cfg_wait = 1000; cfg_rdata = 32'h1234_5678;
    push(1, 1, 1, 32'h0);
    fork
      do_req(1, 0, 32'h0700_0000, 32'h0, lat_m);
      begin
        repeat (5) @(negedge HCLK);
        chk("to_last_wait_penable", 32'(PENABLE), 32'd1);
        chk("to_last_wait_psel", 32'(PSEL), 32'h0080);
        @(negedge HCLK);
        chk("to_abort_psel", 32'(PSEL), 32'h0);
        chk("to_abort_penable", 32'(PENABLE), 32'd0);
      end
    join
    chk("to_latency", 32'(lat_m), 32'd6);
    cfg_wait = 0;
    repeat (2) @(negedge HCLK);

    // TIMEOUT=0: 300-cycle stall completes normally
    z_REQ0 = 1; z_WRITE0 = 0; z_ADDR0 = 32'h0200_0000;
    n = 0;
    while (!z_PENABLE && n < 10) begin
      @(negedge HCLK);
      n++;
    end
    chk("nto_access", 32'(z_PENABLE), 32'd1);
    z_bad = 0;
    repeat (300) begin
      @(negedge HCLK);
      if (z_ACK0 || z_ACK1 || !z_PENABLE) z_bad = 1;
    end
    chk("nto_stall_held", 32'(z_bad), 32'd0);
    z_PREADY = 1; z_PRDATA = 32'hCAFE_F00D;
    @(negedge HCLK);
    chk("nto_ack", 32'(z_ACK0), 32'd1);
    chk("nto_err", 32'(z_ERR), 32'd0);
    chk("nto_rdata", z_RDATA, 32'hCAFE_F00D);
    z_REQ0 = 0; z_PREADY = 0;
    repeat (2) @(negedge HCLK);

    // Reset during ACCESS of a requester-0 transfer
    cfg_wait = 1000;
    REQ0 = 1; WRITE0 = 0; ADDR0 = 32'h0500_0000;
    repeat (3) @(negedge HCLK);
    chk("pre_rst_busy", 32'(BUSY), 32'd1);
    chk("pre_rst_gnt", 32'(GNT_ID), 32'd0);
    #2 HRESETN = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(PSEL), 32'h0);
    chk("mid_rst_penable", 32'(PENABLE), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_gnt", 32'(GNT_ID), 32'd1);
    chk("mid_rst_ack", 32'({ACK1, ACK0}), 32'd0);
    REQ0 = 0;
    cfg_wait = 0;
    @(negedge HCLK);
    HRESETN = 1'b1;

    // Contention straight after reset: grants 0,1,0,1,0,1
    cfg_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 1, 32'h5555_AAAA);
      push(1, 0, 1, 32'h5555_AAAA);
    end
    fork
      for (int i = 0; i < 3; i++) do_req(0, 0, 32'h0A00_0000 + 32'(i), 32'h0, lat0);
      for (int j = 0; j < 3; j++) do_req(1, 1, 32'h0B00_0000 + 32'(j), 32'h77, lat1);
    join

    repeat (4) @(negedge HCLK);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
